// File: rtl/gesture_cmd_sched_pkg.sv
// Command codes and scheduler state encodings, shared with the playback core.
package gesture_cmd_sched_pkg;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_PAUSE = 2'd1;
    localparam logic [1:0] CMD_PLAY  = 2'd2;
    localparam logic [1:0] CMD_NEXT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TRACK    = 2'd1,
        ST_ISSUE    = 2'd2,
        ST_COOLDOWN = 2'd3
    } sched_state_t;

endpackage

// File: rtl/gesture_cmd_sched_classify.sv
// Per-frame hand classifier: pcount/ratio -> command class.
// Purely combinational (latency 0); no flow control.
module gesture_classify
    import gesture_cmd_sched_pkg::*;
#(
    parameter int unsigned PAUSE_LOW  = 18,
    parameter int unsigned PLAY_LOW   = 29,
    parameter int unsigned NEXT_LOW   = 34,
    parameter int unsigned NEXT_HIGH  = 45,
    parameter int unsigned RATIO_TALL = 150
) (
    input  logic [6:0]  pcount,
    input  logic [13:0] ratio,
    output logic [1:0]  frame_class
);

    localparam logic [6:0]  PAUSE_LO = 7'(PAUSE_LOW);
    localparam logic [6:0]  PLAY_LO  = 7'(PLAY_LOW);
    localparam logic [6:0]  NEXT_LO  = 7'(NEXT_LOW);
    localparam logic [6:0]  NEXT_HI  = 7'(NEXT_HIGH);
    localparam logic [13:0] TALL     = 14'(RATIO_TALL);

    always_comb begin
        frame_class = CMD_NONE;
        if (pcount < PAUSE_LO)
            frame_class = CMD_NONE;
        else if (pcount < PLAY_LO)
            frame_class = CMD_PAUSE;
        else if (pcount < NEXT_LO)
            frame_class = CMD_PLAY;
        else if (pcount <= NEXT_HI)
            // Large blobs only count as NEXT when the hand is held upright.
            frame_class = (ratio >= TALL) ? CMD_NEXT : CMD_PLAY;
        else
            frame_class = CMD_NONE;
    end

endmodule

// File: rtl/gesture_cmd_sched.sv
// Debounces per-frame gesture classes into media commands with repeat suppression and cooldown.
// Command appears 1 cycle after the completing frame; held on cmd_valid until cmd_ready, frames ignored meanwhile.
module gesture_cmd_sched
    import gesture_cmd_sched_pkg::*;
#(
    parameter int unsigned PAUSE_LOW       = 18,
    parameter int unsigned PLAY_LOW        = 29,
    parameter int unsigned NEXT_LOW        = 34,
    parameter int unsigned NEXT_HIGH       = 45,
    parameter int unsigned RATIO_TALL      = 150,
    parameter int unsigned STABLE_FRAMES   = 4,
    parameter int unsigned COOLDOWN_FRAMES = 30
) (
    input  logic        clk25,
    input  logic        reset,
    input  logic        frame_valid,
    input  logic [6:0]  pcount,
    input  logic [13:0] ratio,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_code,
    output logic [1:0]  gesture_dbg,
    output logic        busy
);

    localparam logic [3:0] STABLE_N = 4'(STABLE_FRAMES);
    localparam logic [5:0] COOL_N   = 6'(COOLDOWN_FRAMES);

    sched_state_t state;
    logic [1:0]   frame_class;
    logic [1:0]   cand;
    logic [1:0]   last_cmd;
    logic [3:0]   stab_cnt;
    logic [5:0]   cool_cnt;
    logic [3:0]   stab_inc;
    logic [5:0]   cool_inc;

    gesture_classify #(
        .PAUSE_LOW  (PAUSE_LOW),
        .PLAY_LOW   (PLAY_LOW),
        .NEXT_LOW   (NEXT_LOW),
        .NEXT_HIGH  (NEXT_HIGH),
        .RATIO_TALL (RATIO_TALL)
    ) u_classify (
        .pcount      (pcount),
        .ratio       (ratio),
        .frame_class (frame_class)
    );

    // Saturating increments so a stuck input can never wrap a counter.
    always_comb begin
        stab_inc = (stab_cnt == 4'hF) ? stab_cnt : stab_cnt + 4'd1;
        cool_inc = (cool_cnt == 6'h3F) ? cool_cnt : cool_cnt + 6'd1;
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            state       <= ST_IDLE;
            cand        <= CMD_NONE;
            last_cmd    <= CMD_NONE;
            stab_cnt    <= 4'd0;
            cool_cnt    <= 6'd0;
            cmd_valid   <= 1'b0;
            cmd_code    <= CMD_NONE;
            gesture_dbg <= CMD_NONE;
            busy        <= 1'b0;
        end else begin
            if (frame_valid)
                gesture_dbg <= frame_class;

            case (state)
                ST_IDLE: begin
                    if (frame_valid) begin
                        if (frame_class == CMD_NONE) begin
                            last_cmd <= CMD_NONE;
                        end else if (frame_class != last_cmd) begin
                            cand     <= frame_class;
                            stab_cnt <= 4'd1;
                            busy     <= 1'b1;
                            if (STABLE_N <= 4'd1) begin
                                state     <= ST_ISSUE;
                                cmd_valid <= 1'b1;
                                cmd_code  <= frame_class;
                            end else begin
                                state <= ST_TRACK;
                            end
                        end
                    end
                end

                ST_TRACK: begin
                    if (frame_valid) begin
                        if (frame_class == cand) begin
                            stab_cnt <= stab_inc;
                            if (stab_inc >= STABLE_N) begin
                                state     <= ST_ISSUE;
                                cmd_valid <= 1'b1;
                                cmd_code  <= cand;
                            end
                        end else if (frame_class == CMD_NONE) begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            last_cmd <= CMD_NONE;
                            stab_cnt <= 4'd0;
                        end else begin
                            cand     <= frame_class;
                            stab_cnt <= 4'd1;
                        end
                    end
                end

                ST_ISSUE: begin
                    // Frames arriving here are dropped, including one on the handshake cycle.
                    if (cmd_ready) begin
                        state     <= ST_COOLDOWN;
                        last_cmd  <= cand;
                        cool_cnt  <= 6'd0;
                        stab_cnt  <= 4'd0;
                        cmd_valid <= 1'b0;
                        cmd_code  <= CMD_NONE;
                    end
                end

                ST_COOLDOWN: begin
                    if (COOL_N == 6'd0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (frame_valid) begin
                        cool_cnt <= cool_inc;
                        if (cool_inc >= COOL_N) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    cmd_valid <= 1'b0;
                    cmd_code  <= CMD_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gesture_cmd_sched.sv
// Directed bench for gesture_cmd_sched: debounce, suppression, cooldown, backpressure, reset.
module tb_gesture_cmd_sched;

    logic        clk25 = 1'b0;
    logic        reset;
    logic        frame_valid;
    logic [6:0]  pcount;
    logic [13:0] ratio;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_code;
    logic [1:0]  gesture_dbg;
    logic        busy;

    int tests = 0;
    int fails = 0;

    gesture_cmd_sched dut (
        .clk25       (clk25),
        .reset       (reset),
        .frame_valid (frame_valid),
        .pcount      (pcount),
        .ratio       (ratio),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_code    (cmd_code),
        .gesture_dbg (gesture_dbg),
        .busy        (busy)
    );

    always #20 clk25 = ~clk25;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle frame strobe; returns at the negedge after the sampling edge.
    task automatic frame(input logic [6:0] p, input logic [13:0] r);
        @(negedge clk25);
        frame_valid = 1'b1;
        pcount      = p;
        ratio       = r;
        @(negedge clk25);
        frame_valid = 1'b0;
    endtask

    task automatic handshake();
        @(negedge clk25);
        cmd_ready = 1'b1;
        @(negedge clk25);
        cmd_ready = 1'b0;
    endtask

    task automatic cooldown(input string tag);
        repeat (29) frame(7'd0, 14'd0);
        check({tag, "_busy29"}, {7'd0, busy}, 8'd1);
        frame(7'd0, 14'd0);
        check({tag, "_busy30"}, {7'd0, busy}, 8'd0);
    endtask

    initial begin
        reset       = 1'b1;
        frame_valid = 1'b0;
        pcount      = 7'd0;
        ratio       = 14'd0;
        cmd_ready   = 1'b0;
        repeat (3) @(negedge clk25);
        check("rst_valid", {7'd0, cmd_valid}, 8'd0);
        check("rst_code", {6'd0, cmd_code}, 8'd0);
        check("rst_dbg", {6'd0, gesture_dbg}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        reset = 1'b0;

        // 1: PLAY stable for four frames
        frame(7'd30, 14'd0);
        check("t1_busy", {7'd0, busy}, 8'd1);
        check("t1_dbg", {6'd0, gesture_dbg}, 8'd2);
        frame(7'd30, 14'd0);
        frame(7'd30, 14'd0);
        check("t1_novalid3", {7'd0, cmd_valid}, 8'd0);
        frame(7'd30, 14'd0);
        check("t1_valid", {7'd0, cmd_valid}, 8'd1);
        check("t1_code", {6'd0, cmd_code}, 8'd2);
        handshake();
        check("t1_drop", {7'd0, cmd_valid}, 8'd0);
        check("t1_cool_busy", {7'd0, busy}, 8'd1);
        cooldown("t1");

        // 2: candidate switch restarts the stability count
        repeat (3) frame(7'd20, 14'd0);
        frame(7'd40, 14'd200);
        check("t2_novalid", {7'd0, cmd_valid}, 8'd0);
        check("t2_dbg", {6'd0, gesture_dbg}, 8'd3);
        frame(7'd40, 14'd200);
        frame(7'd40, 14'd200);
        check("t2_novalid3", {7'd0, cmd_valid}, 8'd0);
        frame(7'd40, 14'd200);
        check("t2_valid", {7'd0, cmd_valid}, 8'd1);
        check("t2_code", {6'd0, cmd_code}, 8'd3);

        // 3: backpressure for 100 cycles with frames arriving
        for (int i = 0; i < 50; i++) begin
            frame(7'd20, 14'd0);
            check("t3_hold", {5'd0, busy, cmd_valid, cmd_code[1]}, 8'h07);
        end
        check("t3_code", {6'd0, cmd_code}, 8'd3);
        check("t3_dbg", {6'd0, gesture_dbg}, 8'd1);
        // handshake with a coinciding frame, which must not count toward cooldown
        @(negedge clk25);
        cmd_ready   = 1'b1;
        frame_valid = 1'b1;
        pcount      = 7'd0;
        @(negedge clk25);
        cmd_ready   = 1'b0;
        frame_valid = 1'b0;
        check("t3_drop", {7'd0, cmd_valid}, 8'd0);
        cooldown("t3");

        // 4: repeat suppression and cooldown
        repeat (4) frame(7'd20, 14'd0);
        check("t4_valid", {7'd0, cmd_valid}, 8'd1);
        check("t4_code", {6'd0, cmd_code}, 8'd1);
        handshake();
        repeat (10) frame(7'd20, 14'd0);
        check("t4_cool_novalid", {7'd0, cmd_valid}, 8'd0);
        repeat (19) frame(7'd20, 14'd0);
        check("t4_busy29", {7'd0, busy}, 8'd1);
        frame(7'd20, 14'd0);
        check("t4_busy30", {7'd0, busy}, 8'd0);
        repeat (4) frame(7'd20, 14'd0);
        check("t4_suppr_valid", {7'd0, cmd_valid}, 8'd0);
        check("t4_suppr_busy", {7'd0, busy}, 8'd0);
        frame(7'd0, 14'd0);
        repeat (4) frame(7'd20, 14'd0);
        check("t4_reissue_valid", {7'd0, cmd_valid}, 8'd1);
        check("t4_reissue_code", {6'd0, cmd_code}, 8'd1);
        handshake();
        cooldown("t4");

        // 5: wide-but-short blob is PLAY; out-of-range sizes are NONE; class edges
        repeat (4) frame(7'd40, 14'd100);
        check("t5_valid", {7'd0, cmd_valid}, 8'd1);
        check("t5_code", {6'd0, cmd_code}, 8'd2);
        handshake();
        cooldown("t5");
        repeat (4) frame(7'd46, 14'd200);
        check("t5_big_valid", {7'd0, cmd_valid}, 8'd0);
        check("t5_big_busy", {7'd0, busy}, 8'd0);
        check("t5_big_dbg", {6'd0, gesture_dbg}, 8'd0);
        frame(7'd45, 14'd150);
        check("t5_dbg_45_150", {6'd0, gesture_dbg}, 8'd3);
        check("t5_track_busy", {7'd0, busy}, 8'd1);
        frame(7'd34, 14'd149);
        check("t5_dbg_34_149", {6'd0, gesture_dbg}, 8'd2);
        frame(7'd33, 14'd500);
        check("t5_dbg_33", {6'd0, gesture_dbg}, 8'd2);
        frame(7'd29, 14'd0);
        check("t5_dbg_29", {6'd0, gesture_dbg}, 8'd2);
        frame(7'd28, 14'd0);
        check("t5_dbg_28", {6'd0, gesture_dbg}, 8'd1);
        frame(7'd18, 14'd0);
        check("t5_dbg_18", {6'd0, gesture_dbg}, 8'd1);
        frame(7'd17, 14'd0);
        check("t5_dbg_17", {6'd0, gesture_dbg}, 8'd0);
        check("t5_none_busy", {7'd0, busy}, 8'd0);
        check("t5_none_valid", {7'd0, cmd_valid}, 8'd0);

        // 6: reset mid-handshake clears outputs and last command
        repeat (4) frame(7'd40, 14'd200);
        check("t6_next_code", {6'd0, cmd_code}, 8'd3);
        handshake();
        cooldown("t6");
        repeat (4) frame(7'd40, 14'd200);
        check("t6_suppr", {7'd0, cmd_valid}, 8'd0);
        repeat (4) frame(7'd20, 14'd0);
        check("t6_pause_valid", {7'd0, cmd_valid}, 8'd1);
        @(negedge clk25);
        reset       = 1'b1;
        cmd_ready   = 1'b1;
        frame_valid = 1'b1;
        pcount      = 7'd40;
        ratio       = 14'd200;
        @(negedge clk25);
        reset       = 1'b0;
        cmd_ready   = 1'b0;
        frame_valid = 1'b0;
        check("t6_rst_valid", {7'd0, cmd_valid}, 8'd0);
        check("t6_rst_busy", {7'd0, busy}, 8'd0);
        check("t6_rst_code", {6'd0, cmd_code}, 8'd0);
        check("t6_rst_dbg", {6'd0, gesture_dbg}, 8'd0);
        repeat (4) frame(7'd40, 14'd200);
        check("t6_after_valid", {7'd0, cmd_valid}, 8'd1);
        check("t6_after_code", {6'd0, cmd_code}, 8'd3);
        handshake();
        check("t6_final_drop", {7'd0, cmd_valid}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
